// File: rtl/alu_operand_pkg.sv
// Shared encodings and default widths for the ALU second-operand stage.
package alu_operand_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_IMM_W  = 16;

  typedef enum logic [1:0] {
    SEL_REG      = 2'b00,
    SEL_IMM_SEXT = 2'b01,
    SEL_IMM_ZEXT = 2'b10,
    SEL_CALL     = 2'b11
  } selCode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } bufState_t;

endpackage

// File: rtl/operand_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// The main register drives the output; the skid register absorbs one extra entry.
module operand_skid_buffer
  import alu_operand_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iData,
  input  logic              iFlush,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData
);

  bufState_t         state;
  logic [DATA_W-1:0] mainReg;
  logic [DATA_W-1:0] skidReg;
  logic              acc;
  logic              pop;

  // Handshake flags come only from the registered state, so iReady never reaches oReady.
  assign oValid = (state != ST_EMPTY);
  assign oReady = (state != ST_FULL);
  assign oData  = mainReg;
  assign acc    = iValid && oReady;
  assign pop    = oValid && iReady;

  // Flush leaves mainReg alone so the output does not change until the next accept.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state   <= ST_EMPTY;
      mainReg <= '0;
      skidReg <= '0;
    end else if (iFlush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            mainReg <= iData;
            state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && !pop) begin
            skidReg <= iData;
            state   <= ST_FULL;
          end else if (acc && pop) begin
            mainReg <= iData;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            mainReg <= skidReg;
            state   <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU second-operand selector: picks register/forward, immediate or call
// constant at accept time and queues it in a skid buffer toward the ALU.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter int                IMM_W      = DEFAULT_IMM_W,
  parameter logic [DATA_W-1:0] CALL_CONST = {DATA_W{1'b1}}
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [1:0]        iSel,
  input  logic [DATA_W-1:0] iSrc,
  input  logic [IMM_W-1:0]  iImmediate,
  input  logic              iFwdEn,
  input  logic [DATA_W-1:0] iFwdData,
  input  logic              iFlush,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oSrc
);

  logic [DATA_W-1:0] selOperand;

  always_comb begin
    selOperand = '0;
    case (selCode_t'(iSel))
      SEL_REG:      selOperand = iFwdEn ? iFwdData : iSrc;
      SEL_IMM_SEXT: selOperand = DATA_W'($signed(iImmediate));
      SEL_IMM_ZEXT: selOperand = DATA_W'(iImmediate);
      SEL_CALL:     selOperand = CALL_CONST;
    endcase
  end

  operand_skid_buffer #(
    .DATA_W(DATA_W)
  ) skidBuffer (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iValid(iValid),
    .oReady(oReady),
    .iData (selOperand),
    .iFlush(iFlush),
    .oValid(oValid),
    .iReady(iReady),
    .oData (oSrc)
  );

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed requests push expected operands,
// a negedge monitor pops and compares every operand the stage hands to the ALU.
module tb_alu_operand_stage;

  logic        iClk;
  logic        iRst_n;
  logic        iValid;
  logic        oReady;
  logic [1:0]  iSel;
  logic [31:0] iSrc;
  logic [15:0] iImmediate;
  logic        iFwdEn;
  logic [31:0] iFwdData;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  logic [31:0] oSrc;

  logic [31:0] expQ[$];
  int checkCount = 0;
  int passCount  = 0;
  int waitCycles;

  alu_operand_stage dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iValid    (iValid),
    .oReady    (oReady),
    .iSel      (iSel),
    .iSrc      (iSrc),
    .iImmediate(iImmediate),
    .iFwdEn    (iFwdEn),
    .iFwdData  (iFwdData),
    .iFlush    (iFlush),
    .oValid    (oValid),
    .iReady    (iReady),
    .oSrc      (oSrc)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Present one request and hold it until accepted; the expected operand is queued at accept.
  task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] src,
                               input logic [15:0] imm, input logic fwdEn,
                               input logic [31:0] fwdData, input logic [31:0] expected,
                               output int waited);
    iSel       = sel;
    iSrc       = src;
    iImmediate = imm;
    iFwdEn     = fwdEn;
    iFwdData   = fwdData;
    iValid     = 1'b1;
    waited     = 0;
    forever begin
      @(negedge iClk);
      if (oReady) begin
        expQ.push_back(expected);
        break;
      end
      waited++;
      if (waited > 50) begin
        checkCount++;
        $display("[TB] FAIL acceptTimeout: got oReady=0 for %0d cycles, expected accept", waited);
        return;
      end
    end
    @(posedge iClk);
    #1;
  endtask

  always @(negedge iClk) begin
    if (iRst_n && oValid && iReady) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedOutput: got %h, expected no output", oSrc);
      end else begin
        checkOutput("scoreboard", oSrc, expQ.pop_front());
      end
    end
  end

  initial begin
    iRst_n = 1'b0; iValid = 1'b0; iSel = 2'b00; iSrc = '0; iImmediate = '0;
    iFwdEn = 1'b0; iFwdData = '0; iFlush = 1'b0; iReady = 1'b1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    checkOutput("resetValid", {31'd0, oValid}, 32'd0);
    checkOutput("resetReady", {31'd0, oReady}, 32'd1);
    checkOutput("resetSrc", oSrc, 32'd0);
    @(posedge iClk); #1;
    iRst_n = 1'b1;

    $display("[TB] single sign-extended immediate");
    applyStimulus(2'b01, 32'h0, 16'h8001, 1'b0, 32'h0, 32'hFFFF8001, waitCycles);
    iValid = 1'b0;
    @(posedge iClk);
    @(negedge iClk);
    checkOutput("singleDrain", {31'd0, oValid}, 32'd0);
    @(posedge iClk); #1;

    $display("[TB] forward versus select");
    applyStimulus(2'b00, 32'h11, 16'h8001, 1'b1, 32'h22, 32'h22, waitCycles);
    applyStimulus(2'b10, 32'h11, 16'h8001, 1'b1, 32'h22, 32'h00008001, waitCycles);
    applyStimulus(2'b11, 32'h11, 16'h8001, 1'b1, 32'h22, 32'hFFFFFFFF, waitCycles);
    applyStimulus(2'b00, 32'h33, 16'h0000, 1'b0, 32'h44, 32'h33, waitCycles);
    applyStimulus(2'b01, 32'h0, 16'h7FFF, 1'b0, 32'h0, 32'h00007FFF, waitCycles);
    iValid = 1'b0;
    repeat (2) @(posedge iClk); #1;

    $display("[TB] backpressure");
    iReady = 1'b0;
    applyStimulus(2'b00, 32'd1, 16'h0, 1'b0, 32'h0, 32'd1, waitCycles);
    applyStimulus(2'b00, 32'd2, 16'h0, 1'b0, 32'h0, 32'd2, waitCycles);
    iSrc = 32'd3;
    @(negedge iClk);
    checkOutput("fullReady", {31'd0, oReady}, 32'd0);
    checkOutput("fullHoldSrc", oSrc, 32'd1);
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    checkOutput("stallHoldSrc", oSrc, 32'd1);
    @(posedge iClk); #1;
    iReady = 1'b1;
    applyStimulus(2'b00, 32'd3, 16'h0, 1'b0, 32'h0, 32'd3, waitCycles);
    iValid = 1'b0;
    repeat (3) @(posedge iClk); #1;

    $display("[TB] streaming accept with pop");
    for (int i = 5; i <= 7; i++) begin
      applyStimulus(2'b00, 32'(i), 16'h0, 1'b0, 32'h0, 32'(i), waitCycles);
      checkOutput("streamNoStall", 32'(waitCycles), 32'd0);
    end
    iValid = 1'b0;
    repeat (3) @(posedge iClk); #1;

    $display("[TB] flush while full");
    iReady = 1'b0;
    applyStimulus(2'b00, 32'd8, 16'h0, 1'b0, 32'h0, 32'd8, waitCycles);
    applyStimulus(2'b00, 32'd9, 16'h0, 1'b0, 32'h0, 32'd9, waitCycles);
    iSrc   = 32'd10;
    iValid = 1'b1;
    iFlush = 1'b1;
    @(posedge iClk); #1;
    iFlush = 1'b0;
    iValid = 1'b0;
    expQ.delete();
    @(negedge iClk);
    checkOutput("flushValid", {31'd0, oValid}, 32'd0);
    checkOutput("flushReady", {31'd0, oReady}, 32'd1);
    checkOutput("flushHoldSrc", oSrc, 32'd8);
    @(posedge iClk); #1;
    iReady = 1'b1;
    repeat (2) @(posedge iClk); #1;
    applyStimulus(2'b00, 32'h77, 16'h0, 1'b0, 32'h0, 32'h77, waitCycles);
    iValid = 1'b0;
    repeat (3) @(posedge iClk); #1;

    $display("[TB] reset while full");
    iReady = 1'b0;
    applyStimulus(2'b00, 32'hA1, 16'h0, 1'b0, 32'h0, 32'hA1, waitCycles);
    applyStimulus(2'b00, 32'hA2, 16'h0, 1'b0, 32'h0, 32'hA2, waitCycles);
    iValid = 1'b0;
    iRst_n = 1'b0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    expQ.delete();
    @(negedge iClk);
    checkOutput("midResetValid", {31'd0, oValid}, 32'd0);
    checkOutput("midResetReady", {31'd0, oReady}, 32'd1);
    checkOutput("midResetSrc", oSrc, 32'd0);
    @(posedge iClk); #1;
    iReady = 1'b1;
    repeat (3) @(posedge iClk); #1;
    applyStimulus(2'b01, 32'h0, 16'hFFFE, 1'b0, 32'h0, 32'hFFFFFFFE, waitCycles);
    iValid = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
